// File: rtl/mem_ctrl_mp_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_mp_if
// Request/response bundle between the requesters (fetch, load/store, ...) and
// the byte-serial memory controller. One lane per port, flattened so port i
// occupies the i-th slice of each vector.
//   req_valid [N]      request, held until that port's resp_done
//   req_wr    [N]      1 = store
//   req_addr  [32N]    start byte address
//   req_size  [2N]     0 = 1 byte, 1 = 2 bytes, 2/3 = 4 bytes
//   req_wdata [32N]    store data, little-endian
//   resp_done [N]      one-cycle completion pulse
//   resp_data [32N]    load result, zero-extended
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface mem_ctrl_mp_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0]    req_valid;
  logic [NUM_PORTS-1:0]    req_wr;
  logic [32*NUM_PORTS-1:0] req_addr;
  logic [2*NUM_PORTS-1:0]  req_size;
  logic [32*NUM_PORTS-1:0] req_wdata;
  logic [NUM_PORTS-1:0]    resp_done;
  logic [32*NUM_PORTS-1:0] resp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_size, req_wdata,
    input  resp_done, resp_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_size, req_wdata,
    output resp_done, resp_data
  );
endinterface

// File: rtl/mem_ctrl_mp.sv
// -----------------------------------------------------------------------------
// mem_ctrl_mp
// Byte-serial memory controller sharing one 8-bit RAM/IO bus between
// NUM_PORTS requesters. Round-robin arbitration, 1/2/4-byte transfers,
// abort of speculative (non-IO) reads on clr, and IO write stalling while
// the UART buffer is full.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-low reset
//   rdy            global enable; all registers hold while low
//   clr            pipeline flush pulse
//   mem_din        read data, valid one cycle after its address
//   mem_dout       write data byte
//   mem_a          byte address (0 outside a transfer)
//   mem_wr         1 = write strobe
//   io_buffer_full UART buffer full; stalls IO writes
//   req_if         per-port request/response bundle (slave side)
// -----------------------------------------------------------------------------
module mem_ctrl_mp #(
  parameter int                   NUM_PORTS = 2,
  parameter logic [NUM_PORTS-1:0] CLR_MASK  = {NUM_PORTS{1'b1}},
  parameter logic [31:0]          IO_BASE   = 32'h0003_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clr,
  input  logic [7:0]          mem_din,
  output logic [7:0]          mem_dout,
  output logic [31:0]         mem_a,
  output logic                mem_wr,
  input  logic                io_buffer_full,
  mem_ctrl_mp_if.slave        req_if
);

  localparam int             PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PW:0]    NP = (PW+1)'(NUM_PORTS);
  localparam logic [PW-1:0]  LAST_PORT = PW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    TAIL
  } state_e;

  // IO space is the 64 KiB window selected by addr[17:16] of IO_BASE.
  function automatic logic is_io(input logic [31:0] a);
    return a[17:16] == IO_BASE[17:16];
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] byte_ins(input logic [31:0] w, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (k)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  // Index of the last byte; the reserved size code behaves as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  state_e                      state_q, state_d;
  logic [PW-1:0]               port_q, port_d;
  logic [PW-1:0]               rr_ptr_q, rr_ptr_d;
  logic                        wr_q, wr_d;
  logic [31:0]                 addr_q, addr_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic [31:0]                 data_q, data_d;
  logic [1:0]                  k_q, k_d;
  logic [1:0]                  last_q, last_d;
  logic [31:0]                 mem_a_q, mem_a_d;
  logic [7:0]                  mem_dout_q, mem_dout_d;
  logic                        mem_wr_q, mem_wr_d;
  logic [NUM_PORTS-1:0]        resp_done_q, resp_done_d;
  logic [NUM_PORTS-1:0][31:0]  resp_data_q, resp_data_d;

  logic [NUM_PORTS-1:0][31:0]  req_addr_a;
  logic [NUM_PORTS-1:0][31:0]  req_wdata_a;
  logic [NUM_PORTS-1:0][1:0]   req_size_a;

  assign req_addr_a  = req_if.req_addr;
  assign req_wdata_a = req_if.req_wdata;
  assign req_size_a  = req_if.req_size;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter. A port finishing this cycle is skipped so that it
  // cannot be re-granted on a stale, still-held request.
  // ---------------------------------------------------------------------------
  logic [NUM_PORTS-1:0] eligible;
  logic                 grant_valid;
  logic [PW-1:0]        grant_port;
  logic [PW:0]          cand;

  assign eligible = req_if.req_valid & ~resp_done_q;

  always_comb begin
    grant_valid = 1'b0;
    grant_port  = '0;
    cand        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (cand >= NP) cand = cand - NP;
      if (!grant_valid && eligible[cand[PW-1:0]]) begin
        grant_valid = 1'b1;
        grant_port  = cand[PW-1:0];
      end
    end
  end

  // Stall only gates the strobe; the registered address/data stay put.
  logic stall;
  logic abort;

  assign stall = (state_q == XFER) && wr_q && io_buffer_full && is_io(mem_a_q);
  assign abort = clr && !wr_q && CLR_MASK[port_q] && !is_io(addr_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d     = state_q;
    port_d      = port_q;
    rr_ptr_d    = rr_ptr_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    k_d         = k_q;
    last_d      = last_q;
    mem_a_d     = '0;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    resp_done_d = '0;
    resp_data_d = resp_data_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d  = XFER;
          port_d   = grant_port;
          rr_ptr_d = (grant_port == LAST_PORT) ? '0 : grant_port + 1'b1;
          wr_d     = req_if.req_wr[grant_port];
          addr_d   = req_addr_a[grant_port];
          wdata_d  = req_wdata_a[grant_port];
          last_d   = last_idx(req_size_a[grant_port]);
          k_d      = 2'd0;
          data_d   = '0;
          mem_a_d  = req_addr_a[grant_port];
          mem_wr_d = req_if.req_wr[grant_port];
          if (req_if.req_wr[grant_port]) mem_dout_d = req_wdata_a[grant_port][7:0];
        end
      end

      XFER: begin
        if (abort) begin
          state_d = IDLE;
        end else if (wr_q) begin
          if (stall) begin
            mem_a_d  = mem_a_q;
            mem_wr_d = 1'b1;
          end else if (k_q == last_q) begin
            state_d              = IDLE;
            resp_done_d[port_q]  = 1'b1;
          end else begin
            k_d        = k_q + 2'd1;
            mem_a_d    = addr_q + 32'(k_d);
            mem_wr_d   = 1'b1;
            mem_dout_d = byte_sel(wdata_q, k_d);
          end
        end else begin
          // mem_din carries the byte addressed one cycle earlier.
          if (k_q != 2'd0) data_d = byte_ins(data_q, k_q - 2'd1, mem_din);
          if (k_q == last_q) begin
            state_d = TAIL;
          end else begin
            k_d     = k_q + 2'd1;
            mem_a_d = addr_q + 32'(k_d);
          end
        end
      end

      TAIL: begin
        state_d = IDLE;
        if (!abort) begin
          resp_data_d[port_q] = byte_ins(data_q, last_q, mem_din);
          resp_done_d[port_q] = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      port_q      <= '0;
      rr_ptr_q    <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      k_q         <= '0;
      last_q      <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      resp_done_q <= '0;
      resp_data_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      port_q      <= port_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      k_q         <= k_d;
      last_q      <= last_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      resp_done_q <= resp_done_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign mem_a            = mem_a_q;
  assign mem_dout         = mem_dout_q;
  assign mem_wr           = mem_wr_q & ~stall;
  assign req_if.resp_done = resp_done_q;
  assign req_if.resp_data = resp_data_q;

endmodule

// File: tb/tb_mem_ctrl_mp.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl_mp
// Directed bench for mem_ctrl_mp. A two-port instance exercises reads, writes,
// IO stall, clr abort, address wrap, rdy hold and reset mid-transfer; a
// three-port instance exercises round-robin ordering. Inputs are driven on the
// falling edge, outputs sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_mem_ctrl_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clr;

  logic [7:0]  mem_din2;
  logic [7:0]  mem_dout2;
  logic [31:0] mem_a2;
  logic        mem_wr2;
  logic        io_full2;

  logic [7:0]  mem_din3;
  logic [7:0]  mem_dout3;
  logic [31:0] mem_a3;
  logic        mem_wr3;

  int          n_checks = 0;
  int          n_pass   = 0;

  int          wr_cnt = 0;
  logic [31:0] wr_log = '0;
  logic [31:0] wr_addr_first = '0;

  logic [1:0]  seen;
  int          got;
  int          order [6];
  int          wr_base;

  mem_ctrl_mp_if #(.NUM_PORTS(2)) u_if2 ();
  mem_ctrl_mp_if #(.NUM_PORTS(3)) u_if3 ();

  mem_ctrl_mp #(.NUM_PORTS(2)) dut2 (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clr            (clr),
    .mem_din        (mem_din2),
    .mem_dout       (mem_dout2),
    .mem_a          (mem_a2),
    .mem_wr         (mem_wr2),
    .io_buffer_full (io_full2),
    .req_if         (u_if2)
  );

  mem_ctrl_mp #(.NUM_PORTS(3), .CLR_MASK(3'b111)) dut3 (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clr            (clr),
    .mem_din        (mem_din3),
    .mem_dout       (mem_dout3),
    .mem_a          (mem_a3),
    .mem_wr         (mem_wr3),
    .io_buffer_full (1'b0),
    .req_if         (u_if3)
  );

  assign mem_din3 = 8'h5A;

  always #5 clk = ~clk;

  // Read-only image of the RAM locations the bench touches.
  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h11;
      32'h0000_0101: return 8'h22;
      32'h0000_0102: return 8'h33;
      32'h0000_0103: return 8'h44;
      32'h0000_0104: return 8'h55;
      32'h0000_0105: return 8'h66;
      32'h0000_0106: return 8'h77;
      32'h0000_0107: return 8'h88;
      32'hFFFF_FFFF: return 8'h77;
      32'h0000_0000: return 8'h88;
      default:       return 8'h00;
    endcase
  endfunction

  // Memory model: data one cycle after address; writes shift into a log.
  always @(posedge clk) begin
    mem_din2 <= rom(mem_a2);
    if (mem_wr2) begin
      if (wr_cnt == 0) wr_addr_first <= mem_a2;
      wr_log <= {mem_dout2, wr_log[31:8]};
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
  endtask

  task automatic set_req(input int p, input logic w, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] wd);
    u_if2.req_valid[p]           = 1'b1;
    u_if2.req_wr[p]              = w;
    u_if2.req_addr[32*p +: 32]   = a;
    u_if2.req_size[2*p +: 2]     = sz;
    u_if2.req_wdata[32*p +: 32]  = wd;
  endtask

  // Read of n bytes: addresses in t+1..t+n, TAIL in t+n+1, done in t+n+2.
  task automatic do_read(input int p, input logic [31:0] a, input logic [1:0] sz,
                         input int n, input logic [31:0] exp_v);
    @(negedge clk);
    set_req(p, 1'b0, a, sz, 32'h0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      check($sformatf("rd_p%0d_addr%0d", p, k), mem_a2, a + 32'(k));
      check($sformatf("rd_p%0d_wr%0d", p, k), 32'(mem_wr2), 32'h0);
    end
    @(negedge clk); #1;
    check($sformatf("rd_p%0d_tail", p), 32'(u_if2.resp_done), 32'h0);
    @(negedge clk);
    u_if2.req_valid[p] = 1'b0;
    #1;
    check($sformatf("rd_p%0d_done", p), 32'(u_if2.resp_done), 32'(1 << p));
    check($sformatf("rd_p%0d_data", p), u_if2.resp_data[32*p +: 32], exp_v);
  endtask

  // Write of n bytes with an optional clr pulse during byte clr_k.
  task automatic do_write(input int p, input logic [31:0] a, input logic [1:0] sz,
                          input int n, input logic [31:0] wd, input int clr_k);
    logic [31:0] sh;
    wr_base = wr_cnt;
    @(negedge clk);
    set_req(p, 1'b1, a, sz, wd);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      clr = (k == clr_k);
      #1;
      sh = wd >> (8 * k);
      check($sformatf("wr_p%0d_addr%0d", p, k), mem_a2, a + 32'(k));
      check($sformatf("wr_p%0d_wr%0d", p, k), 32'(mem_wr2), 32'h1);
      check($sformatf("wr_p%0d_dout%0d", p, k), 32'(mem_dout2), {24'h0, sh[7:0]});
    end
    @(negedge clk);
    clr = 1'b0;
    u_if2.req_valid[p] = 1'b0;
    #1;
    check($sformatf("wr_p%0d_done", p), 32'(u_if2.resp_done), 32'(1 << p));
    check($sformatf("wr_p%0d_count", p), 32'(wr_cnt - wr_base), 32'(n));
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; clr = 1'b0; io_full2 = 1'b0;
    u_if2.req_valid = '0; u_if2.req_wr = '0; u_if2.req_addr = '0;
    u_if2.req_size  = '0; u_if2.req_wdata = '0;
    u_if3.req_valid = '0; u_if3.req_wr = '0; u_if3.req_addr = '0;
    u_if3.req_size  = '0; u_if3.req_wdata = '0;
    for (int i = 0; i < 6; i++) order[i] = -1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_a", mem_a2, 32'h0);
    check("rst_mem_wr", 32'(mem_wr2), 32'h0);
    check("rst_mem_dout", 32'(mem_dout2), 32'h0);
    check("rst_done", 32'(u_if2.resp_done), 32'h0);
    check("rst_data0", u_if2.resp_data[31:0], 32'h0);
    check("rst_data1", u_if2.resp_data[63:32], 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Port 0 four-byte read
    do_read(0, 32'h0000_0100, 2'd2, 4, 32'h4433_2211);

    // Port 1 one-byte IO write with 3 stall cycles
    wr_base = wr_cnt;
    @(negedge clk);
    io_full2 = 1'b1;
    set_req(1, 1'b1, 32'h0003_0000, 2'd0, 32'h0000_00A5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check($sformatf("io_stall_wr%0d", c), 32'(mem_wr2), 32'h0);
      check($sformatf("io_stall_a%0d", c), mem_a2, 32'h0003_0000);
      check($sformatf("io_stall_done%0d", c), 32'(u_if2.resp_done), 32'h0);
    end
    @(negedge clk);
    io_full2 = 1'b0;
    #1;
    check("io_wr_strobe", 32'(mem_wr2), 32'h1);
    check("io_wr_dout", 32'(mem_dout2), 32'h0000_00A5);
    @(negedge clk);
    u_if2.req_valid[1] = 1'b0;
    #1;
    check("io_wr_done", 32'(u_if2.resp_done), 32'h2);
    check("io_wr_count", 32'(wr_cnt - wr_base), 32'h1);
    check("io_wr_byte", {24'h0, wr_log[31:24]}, 32'h0000_00A5);

    // clr aborts a 4-byte RAM read from port 0 at t+2
    @(negedge clk);
    set_req(0, 1'b0, 32'h0000_0104, 2'd2, 32'h0);
    @(negedge clk); #1;
    check("abort_a0", mem_a2, 32'h0000_0104);
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("abort_a1", mem_a2, 32'h0000_0105);
    @(negedge clk);
    clr = 1'b0;
    u_if2.req_valid[0] = 1'b0;
    #1;
    check("abort_idle_a", mem_a2, 32'h0);
    seen = '0;
    repeat (6) begin
      @(negedge clk); #1;
      seen = seen | u_if2.resp_done;
    end
    check("abort_no_done", 32'(seen), 32'h0);
    check("abort_data_kept", u_if2.resp_data[31:0], 32'h4433_2211);

    // clr during a write is ignored
    do_write(0, 32'h0000_0200, 2'd2, 4, 32'hDEAD_BEEF, 1);
    check("wr_log_word", wr_log, 32'hDEAD_BEEF);

    // Size code 3 behaves as 4 bytes
    do_read(0, 32'h0000_0104, 2'd3, 4, 32'h8877_6655);

    // Port 1 word read then a wrapping 2-byte read (zero-extended)
    do_read(1, 32'h0000_0100, 2'd2, 4, 32'h4433_2211);
    do_read(1, 32'hFFFF_FFFF, 2'd1, 2, 32'h0000_8877);

    // rdy low in IDLE holds off the grant
    @(negedge clk);
    rdy = 1'b0;
    set_req(1, 1'b0, 32'h0000_0102, 2'd0, 32'h0);
    repeat (2) begin
      @(negedge clk); #1;
      check("rdy_hold_a", mem_a2, 32'h0);
    end
    @(negedge clk);
    rdy = 1'b1;
    #1;
    check("rdy_release_a", mem_a2, 32'h0);
    @(negedge clk); #1;
    check("rdy_xfer_a", mem_a2, 32'h0000_0102);
    @(negedge clk);
    @(negedge clk);
    u_if2.req_valid[1] = 1'b0;
    #1;
    check("rdy_done", 32'(u_if2.resp_done), 32'h2);
    check("rdy_data", u_if2.resp_data[63:32], 32'h0000_0033);

    // Reset in the middle of a port 0 write
    @(negedge clk);
    set_req(0, 1'b1, 32'h0000_0300, 2'd2, 32'h0102_0304);
    @(negedge clk); #1;
    check("rstw_a0", mem_a2, 32'h0000_0300);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    u_if2.req_valid[0] = 1'b0;
    #1;
    check("rstw_mem_wr", 32'(mem_wr2), 32'h0);
    check("rstw_mem_a", mem_a2, 32'h0);
    check("rstw_data0", u_if2.resp_data[31:0], 32'h0);
    seen = u_if2.resp_done;
    repeat (5) begin
      @(negedge clk); #1;
      seen = seen | u_if2.resp_done;
    end
    check("rstw_no_done", 32'(seen), 32'h0);

    // After reset, port 0 is served first
    @(negedge clk);
    set_req(0, 1'b0, 32'h0000_0100, 2'd0, 32'h0);
    set_req(1, 1'b0, 32'h0000_0101, 2'd0, 32'h0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    u_if2.req_valid[0] = 1'b0;
    #1;
    check("rstw_first_done", 32'(u_if2.resp_done), 32'h1);
    check("rstw_first_data", u_if2.resp_data[31:0], 32'h0000_0011);
    repeat (2) @(negedge clk);
    @(negedge clk);
    u_if2.req_valid[1] = 1'b0;
    #1;
    check("rstw_second_done", 32'(u_if2.resp_done), 32'h2);
    check("rstw_second_data", u_if2.resp_data[63:32], 32'h0000_0022);

    // Three ports requesting continuously: grant order 0,1,2,0,1,2
    @(negedge clk);
    u_if3.req_valid = 3'b111;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (u_if3.resp_done[i] && got < 6) begin
          order[got] = i;
          got++;
        end
      end
    end
    u_if3.req_valid = '0;
    check("arb_grants", 32'(got), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("arb_order%0d", i), 32'(order[i]), 32'(i % 3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
